// File: rtl/moving_avg_mc.sv
// moving_avg_mc: multi-lane moving-average filter with a run-time selectable
// power-of-two window. All lanes share one strobe, one write pointer and one
// EMPTY -> FILL -> RUN fill state machine.
// Optional build macro MOVING_AVG_ROUND_EN: round half up instead of truncating.
// MAX_WINDOW_SHIFT must be at least 1.
module moving_avg_mc #(
  parameter int DATA_WIDTH       = 16,
  parameter int MAX_WINDOW_SHIFT = 6,
  parameter int NUM_CH           = 2,
  parameter bit SIGNED           = 1'b1
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic                                   clear,
  input  logic [$clog2(MAX_WINDOW_SHIFT+1)-1:0]  window_shift,
  input  logic [NUM_CH*DATA_WIDTH-1:0]           data_in,
  input  logic                                   input_strobe,
  output logic [NUM_CH*DATA_WIDTH-1:0]           data_out,
  output logic                                   output_strobe,
  output logic                                   full
);

  localparam int DEPTH = 1 << MAX_WINDOW_SHIFT;
  localparam int AW    = MAX_WINDOW_SHIFT;
  localparam int WS_W  = $clog2(MAX_WINDOW_SHIFT + 1);
  localparam int SUM_W = DATA_WIDTH + MAX_WINDOW_SHIFT;
  localparam int EXT_W = SUM_W + 1;

  typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;

  function automatic logic [WS_W-1:0] clamp_ws(input logic [WS_W-1:0] ws);
    if (int'(ws) > MAX_WINDOW_SHIFT) return WS_W'(MAX_WINDOW_SHIFT);
    return ws;
  endfunction

  function automatic logic signed [EXT_W-1:0] ext_sample(input logic [DATA_WIDTH-1:0] x);
    logic fb;
    fb = SIGNED ? x[DATA_WIDTH-1] : 1'b0;
    return {{(EXT_W-DATA_WIDTH){fb}}, x};
  endfunction

  function automatic logic signed [EXT_W-1:0] ext_sum(input logic [SUM_W-1:0] s);
    logic fb;
    fb = SIGNED ? s[SUM_W-1] : 1'b0;
    return {fb, s};
  endfunction

  // Divide by the window; the extra top bit absorbs the rounding increment.
  function automatic logic [DATA_WIDTH-1:0] scale_avg(input logic signed [EXT_W-1:0] s,
                                                      input logic [WS_W-1:0] ws);
    logic signed [EXT_W-1:0] r;
`ifdef MOVING_AVG_ROUND_EN
    logic signed [EXT_W-1:0] half;
    half = '0;
    if (ws != '0) half = EXT_W'(1) << (ws - 1'b1);
    r = (s + half) >>> ws;
`else
    r = s >>> ws;
`endif
    return r[DATA_WIDTH-1:0];
  endfunction

  state_t                  state;
  logic [WS_W-1:0]         ws_act;
  logic [AW-1:0]           wr_addr;
  logic [AW:0]             fill_cnt;
  logic [SUM_W-1:0]        sum_q  [NUM_CH];
  logic [DATA_WIDTH-1:0]   dline  [NUM_CH][DEPTH];

  logic [WS_W-1:0]         ws_req, ws_eff;
  logic                    win_chg, accept;
  state_t                  st_eff, nxt_state;
  logic [AW:0]             fill_eff, nxt_fill, w_m1;
  logic [AW-1:0]           rd_addr;
  logic                    vld_p0;
  logic signed [EXT_W-1:0] upd_p0 [NUM_CH];
  logic [DATA_WIDTH-1:0]   avg_p0 [NUM_CH];

  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   avg_p1 [NUM_CH];

  // Stage 0: window-change override, next fill state and per-lane updated sums
  always_comb begin
    ws_req    = clamp_ws(window_shift);
    win_chg   = enable && !clear && (ws_req != ws_act);
    accept    = enable && !clear && input_strobe;
    ws_eff    = win_chg ? ws_req : ws_act;
    st_eff    = win_chg ? EMPTY : state;
    fill_eff  = win_chg ? '0 : fill_cnt;
    w_m1      = ((AW+1)'(1) << ws_eff) - (AW+1)'(1);
    rd_addr   = wr_addr - w_m1[AW-1:0] - AW'(1);
    nxt_state = st_eff;
    nxt_fill  = fill_eff;
    vld_p0    = 1'b0;
    if (accept) begin
      case (st_eff)
        EMPTY: begin
          nxt_fill = (AW+1)'(1);
          if (w_m1 == '0) begin
            nxt_state = RUN;
            vld_p0    = 1'b1;
          end else begin
            nxt_state = FILL;
          end
        end
        FILL: begin
          nxt_fill = fill_eff + (AW+1)'(1);
          if (fill_eff == w_m1) begin
            nxt_state = RUN;
            vld_p0    = 1'b1;
          end
        end
        RUN:     vld_p0 = 1'b1;
        default: nxt_state = EMPTY;
      endcase
    end
    for (int k = 0; k < NUM_CH; k++) begin
      upd_p0[k] = ext_sample(data_in[k*DATA_WIDTH +: DATA_WIDTH]);
      if (st_eff != EMPTY) upd_p0[k] = upd_p0[k] + ext_sum(sum_q[k]);
      if (st_eff == RUN)   upd_p0[k] = upd_p0[k] - ext_sample(dline[k][rd_addr]);
      avg_p0[k] = scale_avg(upd_p0[k], ws_eff);
    end
  end

  // Delay line: one shared write pointer, written only on accepted strobes
  always_ff @(posedge clock) begin
    if (reset_n && accept) begin
      for (int k = 0; k < NUM_CH; k++)
        dline[k][wr_addr] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage 1: fill state, sums, pointer and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= EMPTY;
      fill_cnt <= '0;
      wr_addr  <= '0;
      ws_act   <= ws_req;
      full     <= 1'b0;
      vld_p1   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        sum_q[k]  <= '0;
        avg_p1[k] <= '0;
      end
    end else if (!enable) begin
      vld_p1 <= 1'b0;
    end else if (clear) begin
      state    <= EMPTY;
      fill_cnt <= '0;
      full     <= 1'b0;
      vld_p1   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) sum_q[k] <= '0;
    end else begin
      ws_act   <= ws_eff;
      state    <= nxt_state;
      fill_cnt <= nxt_fill;
      full     <= (nxt_state == RUN);
      vld_p1   <= vld_p0;
      if (win_chg) begin
        for (int k = 0; k < NUM_CH; k++) sum_q[k] <= '0;
      end
      if (accept) begin
        wr_addr <= wr_addr + AW'(1);
        for (int k = 0; k < NUM_CH; k++) sum_q[k] <= upd_p0[k][SUM_W-1:0];
      end
      if (vld_p0) begin
        for (int k = 0; k < NUM_CH; k++) avg_p1[k] <= avg_p0[k];
      end
    end
  end

  // Pack the lane averages onto the output bus
  always_comb begin
    data_out = '0;
    for (int k = 0; k < NUM_CH; k++) data_out[k*DATA_WIDTH +: DATA_WIDTH] = avg_p1[k];
  end

  assign output_strobe = vld_p1;

endmodule

// File: tb/tb_moving_avg_mc.sv
// Directed bench for moving_avg_mc (DATA_WIDTH=16, MAX_WINDOW_SHIFT=6, NUM_CH=2, SIGNED=1).
module tb_moving_avg_mc;
  localparam int DW  = 16;
  localparam int WSW = 3;
`ifdef MOVING_AVG_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b1;
  logic           clear = 1'b0;
  logic [WSW-1:0] window_shift = 3'd2;
  logic [2*DW-1:0] data_in = '0;
  logic           input_strobe = 1'b0;
  logic [2*DW-1:0] data_out;
  logic           output_strobe;
  logic           full;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] l0;
    logic [15:0] l1;
    logic        os;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        f;
  } vec_t;

  vec_t ramp [8];

  always #5 clock = ~clock;

  moving_avg_mc dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .clear         (clear),
    .window_shift  (window_shift),
    .data_in       (data_in),
    .input_strobe  (input_strobe),
    .data_out      (data_out),
    .output_strobe (output_strobe),
    .full          (full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [15:0] l0, input logic [15:0] l1);
    data_in = {l1, l0};
    input_strobe = 1'b1;
    cyc();
    input_strobe = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic os, input logic [15:0] e0,
                            input logic [15:0] e1, input logic f);
    check({nm, "_ostb"}, 32'(output_strobe), 32'(os));
    if (os) begin
      check({nm, "_lane0"}, 32'(data_out[15:0]), 32'(e0));
      check({nm, "_lane1"}, 32'(data_out[31:16]), 32'(e1));
    end
    check({nm, "_full"}, 32'(full), 32'(f));
  endtask

  task automatic idle(input int n, input string nm);
    repeat (n) begin
      cyc();
      check({nm, "_idle_ostb"}, 32'(output_strobe), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ramp[0] = '{16'd1, 16'd100, 1'b0, 16'd0, 16'd0, 1'b0};
    ramp[1] = '{16'd2, 16'd100, 1'b0, 16'd0, 16'd0, 1'b0};
    ramp[2] = '{16'd3, 16'd100, 1'b0, 16'd0, 16'd0, 1'b0};
    ramp[3] = '{16'd4, 16'd100, 1'b1, 16'(2 + RND), 16'd100, 1'b1};
    ramp[4] = '{16'd5, 16'd100, 1'b1, 16'(3 + RND), 16'd100, 1'b1};
    ramp[5] = '{16'd6, 16'd100, 1'b1, 16'(4 + RND), 16'd100, 1'b1};
    ramp[6] = '{16'd7, 16'd100, 1'b1, 16'(5 + RND), 16'd100, 1'b1};
    ramp[7] = '{16'd8, 16'd100, 1'b1, 16'(6 + RND), 16'd100, 1'b1};

    // Reset state
    repeat (3) cyc();
    check("rst_data_out", data_out, 32'd0);
    check("rst_ostb", 32'(output_strobe), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Ramp, W=4, one strobe every 3 cycles
    for (int i = 0; i < 8; i++) begin
      strobe(ramp[i].l0, ramp[i].l1);
      expect_out($sformatf("ramp%0d", i + 1), ramp[i].os, ramp[i].e0, ramp[i].e1, ramp[i].f);
      idle(2, "ramp_gap");
    end

    // Clear together with a strobe: sample dropped, data_out kept
    clear = 1'b1;
    strobe(16'd50, 16'd50);
    clear = 1'b0;
    check("clr_ostb", 32'(output_strobe), 32'd0);
    check("clr_full", 32'(full), 32'd0);
    check("clr_data_kept", data_out, {16'd100, 16'(6 + RND)});
    for (int i = 1; i <= 4; i++) begin
      strobe(16'd50, 16'd50);
      expect_out($sformatf("clr_refill%0d", i), (i == 4), 16'd50, 16'd50, (i == 4));
    end

    // enable low: strobes and window changes ignored
    enable = 1'b0;
    window_shift = 3'd3;
    for (int i = 0; i < 3; i++) begin
      strobe(16'd999, 16'd999);
      check("en0_ostb", 32'(output_strobe), 32'd0);
      check("en0_full", 32'(full), 32'd1);
      check("en0_data", data_out, {16'd50, 16'd50});
    end
    window_shift = 3'd2;
    enable = 1'b1;
    strobe(16'd50, 16'd50);
    expect_out("en1_resume", 1'b1, 16'd50, 16'd50, 1'b1);

    // Window change 4 -> 8 mid-stream
    window_shift = 3'd3;
    cyc();
    check("wchg_full", 32'(full), 32'd0);
    check("wchg_ostb", 32'(output_strobe), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      strobe(16'd50, 16'd50);
      expect_out($sformatf("w8_s%0d", i), (i == 8), 16'd50, 16'd50, (i == 8));
    end

    // Clamp 7 -> 6 (W=64), back-to-back ramp across delay-line wraps
    window_shift = 3'd7;
    cyc();
    check("w64_full", 32'(full), 32'd0);
    for (int k = 1; k <= 200; k++) begin
      strobe(16'(k), 16'd0);
      expect_out($sformatf("w64_k%0d", k), (k >= 64), 16'(k - 32 + RND), 16'd0, (k >= 64));
    end

    // W=1: window change with a strobe in the same cycle
    window_shift = 3'd0;
    strobe(16'd7, 16'd9);
    expect_out("w1_first", 1'b1, 16'd7, 16'd9, 1'b1);
    strobe(16'd3, 16'd4);
    expect_out("w1_second", 1'b1, 16'd3, 16'd4, 1'b1);

    // Signed W=2: floor vs round half up on negative sums
    window_shift = 3'd1;
    strobe(16'hFFFF, 16'd0);
    expect_out("sgn_s1", 1'b0, 16'd0, 16'd0, 1'b0);
    strobe(16'hFFFE, 16'd0);
    expect_out("sgn_s2", 1'b1, (RND != 0) ? 16'hFFFF : 16'hFFFE, 16'd0, 1'b1);
    strobe(16'hFFFF, 16'd0);
    expect_out("sgn_s3", 1'b1, (RND != 0) ? 16'hFFFF : 16'hFFFE, 16'd0, 1'b1);
    strobe(16'hFFFE, 16'd0);
    expect_out("sgn_s4", 1'b1, (RND != 0) ? 16'hFFFF : 16'hFFFE, 16'd0, 1'b1);

    // Reset in RUN: everything cleared, refill needed
    reset_n = 1'b0;
    cyc();
    check("rst2_data_out", data_out, 32'd0);
    check("rst2_ostb", 32'(output_strobe), 32'd0);
    check("rst2_full", 32'(full), 32'd0);
    reset_n = 1'b1;
    strobe(16'd10, 16'd20);
    expect_out("rst2_s1", 1'b0, 16'd0, 16'd0, 1'b0);
    strobe(16'd20, 16'd40);
    expect_out("rst2_s2", 1'b1, 16'd15, 16'd30, 1'b1);
    idle(2, "tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
